// File: rtl/demux14_stream.sv
// demux14_stream: registered 1-to-4 stream demultiplexer.
// S picks the destination channel (00->Y1, 01->Y2, 10->Y3, 11->Y4).
// Each channel holds one word behind a valid/ready handshake.
// Optional feature macro: DEMUX_BEAT_CNT_EN (accepted-beat counter on beat_cnt).
//
// Handshake rules:
//   Input side: a beat transfers on a rising edge where in_valid and in_ready are
//   both high. in_ready is combinational from S, the selected channel's valid
//   flag and its ready input. The producer must not derive in_valid from in_ready.
//   Output side: channel k transfers on a rising edge where Vk and Rk are both
//   high. Yk and Vk stay stable while Vk=1 and Rk=0.
module demux14_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        S,
  input  logic [DATA_W-1:0] D,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] Y1,
  output logic [DATA_W-1:0] Y2,
  output logic [DATA_W-1:0] Y3,
  output logic [DATA_W-1:0] Y4,
  output logic              V1,
  output logic              V2,
  output logic              V3,
  output logic              V4,
  input  logic              R1,
  input  logic              R2,
  input  logic              R3,
  input  logic              R4,
  output logic [CNT_W-1:0]  beat_cnt
);

  logic [3:0]        r_vec;
  logic [3:0]        sel_dec;
  logic [3:0]        load;
  logic              accept;
  logic [3:0]        v_q;
  logic [3:0]        v_d;
  logic [DATA_W-1:0] y_q [4];
  logic [DATA_W-1:0] y_d [4];

  assign r_vec   = {R4, R3, R2, R1};
  assign sel_dec = 4'b0001 << S;

  // Selected channel can take a beat when it is empty or draining this cycle.
  always_comb begin
    in_ready = ~rst & (~v_q[S] | r_vec[S]);
    accept   = in_valid & in_ready;
    load     = {4{accept}} & sel_dec;
  end

  // Per-channel next state: load wins over drain; data is never cleared on drain.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      v_d[k] = load[k] | (v_q[k] & ~r_vec[k]);
      y_d[k] = load[k] ? D : y_q[k];
    end
  end

  // Channel holding registers; reset discards any pending words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= y_d[k];
      end
    end
  end

  assign Y1 = y_q[0];
  assign Y2 = y_q[1];
  assign Y3 = y_q[2];
  assign Y4 = y_q[3];
  assign V1 = v_q[0];
  assign V2 = v_q[1];
  assign V3 = v_q[2];
  assign V4 = v_q[3];

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count accepted beats, wrapping naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux14_stream.sv
// Bench for demux14_stream: directed scenarios plus random traffic, scored
// against a per-channel expected queue fed at accept time.
module tb_demux14_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic [1:0]        S;
  logic [DATA_W-1:0] D;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Y1, Y2, Y3, Y4;
  logic              V1, V2, V3, V4;
  logic              R1, R2, R3, R4;
  logic [CNT_W-1:0]  beat_cnt;

  demux14_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .S(S), .D(D), .in_valid(in_valid), .in_ready(in_ready),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
    .V1(V1), .V2(V2), .V3(V3), .V4(V4),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4),
    .beat_cnt(beat_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] exp_q [4][$];   // words owed to each channel, oldest first
  bit                occ [4];        // channel holds a word after the next edge
  logic [CNT_W-1:0]  exp_cnt;        // model count visible now
  logic [CNT_W-1:0]  exp_cnt_next;   // model count after the next edge
  int                checks;
  int                failures;

  logic [DATA_W-1:0] y_arr [4];
  logic [3:0]        v_vec;
  logic [3:0]        r_drv;

  always_comb begin
    y_arr[0] = Y1; y_arr[1] = Y2; y_arr[2] = Y3; y_arr[3] = Y4;
    v_vec    = {V4, V3, V2, V1};
  end
  assign {R4, R3, R2, R1} = r_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      occ[k] = 1'b0;
    end
    exp_cnt      = '0;
    exp_cnt_next = '0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the edge, check in_ready against the
  // model, and record what the coming edge must do.
  task automatic cycle(input bit v, input logic [1:0] s, input logic [DATA_W-1:0] d,
                       input logic [3:0] r);
    bit exp_rdy;
    bit acc;
    @(posedge clk);
    exp_cnt = exp_cnt_next;
    #1;
    in_valid = v; S = s; D = d; r_drv = r;
    #1;
    exp_rdy = !occ[s] || r[s];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    if (acc) begin
      exp_q[s].push_back(d);
      exp_cnt_next = exp_cnt + 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (acc && (int'(s) == k)) occ[k] = 1'b1;
      else if (r[k])             occ[k] = 1'b0;
    end
  endtask

  // Asserts reset away from any edge and checks the immediate clearing.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    model_clear();
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_v", {28'd0, v_vec}, 32'd0);
    for (int k = 0; k < 4; k++) check("rst_y", {24'd0, y_arr[k]}, 32'd0);
    check("rst_cnt", {16'd0, beat_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (v_vec[k] && r_drv[k]) begin
          if (exp_q[k].size() == 0) begin
            check("spurious_valid", {28'd0, v_vec}, 32'd0);
          end else begin
            check("y_data", {24'd0, y_arr[k]}, {24'd0, exp_q[k].pop_front()});
          end
        end
      end
`ifdef DEMUX_BEAT_CNT_EN
      check("beat_cnt", {16'd0, beat_cnt}, {16'd0, exp_cnt});
`else
      check("beat_cnt_tied", {16'd0, beat_cnt}, 32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; S = 2'd0; D = '0; r_drv = 4'h0;
    model_clear();
    #12;
    check("init_v", {28'd0, v_vec}, 32'd0);
    check("init_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Reset with channel 2 holding data.
    cycle(1, 2'd1, 8'h99, 4'h0);
    cycle(0, 2'd0, 8'h00, 4'h0);
    do_reset();

    // Routing, all consumers ready.
    cycle(1, 2'd0, 8'h11, 4'hF);
    cycle(1, 2'd1, 8'h22, 4'hF);
    cycle(1, 2'd2, 8'h33, 4'hF);
    cycle(1, 2'd3, 8'h44, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);

    // Backpressure on channel 3, other channel keeps flowing.
    cycle(1, 2'd2, 8'hA5, 4'b1011);
    cycle(1, 2'd2, 8'h5A, 4'b1011);
    check("stall_y3_hold", {24'd0, Y3}, 32'hA5);
    cycle(1, 2'd2, 8'h5A, 4'b1011);
    cycle(1, 2'd0, 8'h77, 4'b1011);
    cycle(1, 2'd2, 8'h5A, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'b1011);
    #3;
    check("reload_v3", {31'd0, V3}, 32'd1);
    check("reload_y3", {24'd0, Y3}, 32'h5A);
    cycle(0, 2'd0, 8'h00, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);

    // Back-to-back on channel 4.
    for (int i = 0; i < 8; i++) cycle(1, 2'd3, 8'(i), 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);

    // Reset mid-operation with channels 1 and 3 full.
    cycle(1, 2'd0, 8'h5C, 4'h0);
    cycle(1, 2'd2, 8'hC5, 4'h0);
    cycle(0, 2'd0, 8'h00, 4'h0);
    do_reset();
    cycle(1, 2'd0, 8'hC3, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    #3;
    check("post_rst_y1", {24'd0, Y1}, 32'hC3);

`ifdef DEMUX_BEAT_CNT_EN
    // Counter wrap: preload to 0xFFFE, then three accepts.
    do_reset();
    for (int i = 0; i < 65534; i++) cycle(1, 2'($urandom_range(0, 3)), 8'($urandom), 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    #3; check("cnt_preload", {16'd0, beat_cnt}, 32'hFFFE);
    cycle(1, 2'd1, 8'h01, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    #3; check("cnt_ffff", {16'd0, beat_cnt}, 32'hFFFF);
    cycle(1, 2'd1, 8'h02, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    #3; check("cnt_wrap", {16'd0, beat_cnt}, 32'h0000);
    cycle(1, 2'd1, 8'h03, 4'hF);
    cycle(0, 2'd0, 8'h00, 4'hF);
    #3; check("cnt_one", {16'd0, beat_cnt}, 32'h0001);
    // Stalled attempts must not count.
    cycle(1, 2'd0, 8'h10, 4'h0);
    cycle(1, 2'd0, 8'h11, 4'h0);
    cycle(1, 2'd0, 8'h11, 4'h0);
    cycle(0, 2'd0, 8'h00, 4'h0);
    #3; check("cnt_stall", {16'd0, beat_cnt}, 32'h0002);
    cycle(0, 2'd0, 8'h00, 4'hF);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom));
    end
    for (int i = 0; i < 3; i++) cycle(0, 2'd0, 8'h00, 4'hF);
    @(posedge clk);
    #3;
    for (int k = 0; k < 4; k++) check("drained", exp_q[k].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux14_stream.md
Name: demux14_stream

Overview:
- Registered 1-to-4 demultiplexer that routes one input data stream to one of four output channels.
- Destination is chosen by the 2-bit select S: 00→Y1, 01→Y2, 10→Y3, 11→Y4.
- Each output channel has a one-entry holding register with a valid/ready handshake, so a stalled channel does not corrupt data already delivered to the others.
- It is the receiving counterpart of the 4:1 select path and sits between a single producer and four independent consumers in the lab datapath.

Parameters:
- DATA_W, 8: width of the data word on D and on Y1..Y4.
- CNT_W, 16: width of the optional accepted-beat counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- S  input  2  destination select; sampled only in the cycle a beat is accepted.
- D  input  DATA_W  input data word.
- in_valid  input  1  producer has a valid word on D/S.
- in_ready  output  1  block accepts D this cycle.
- Y1..Y4  output  DATA_W each  channel data registers.
- V1..V4  output  1 each  channel register holds valid data.
- R1..R4  input  1 each  consumer k takes Yk this cycle.
- beat_cnt  output  CNT_W  total accepted beats; optional-feature dependent.

Behaviour:
- Reset (async, rst=1): V1..V4=0, Y1..Y4=0, beat_cnt=0. Any data held in the registers is discarded. Reset asserted mid-transfer drops pending beats without completing them. in_ready is 0 while rst=1.
- Channel s = channel selected by S.
- Combinational in_ready = ~rst & (~Vs | Rs). This is a comb path from S, Rk and Vk; the producer must not make in_valid depend on in_ready.
- Accept = in_valid & in_ready. On accept: Ys ← D, Vs ← 1 at the next edge.
- Latency: D appears on Ys one cycle after accept.
- Channel k drain: Vk & Rk with no concurrent load into k → Vk ← 0. Yk holds its last value; it is not cleared.
- Simultaneous drain and load on the same channel (Vs=1, Rs=1, accept): Ys ← new D and Vs stays 1. Full throughput is one beat per cycle per channel.
- Channels are independent: a load into channel s never alters Yk or Vk for k≠s. Multiple channels may drain in the same cycle.
- Stall: Vs=1 & Rs=0 → in_ready=0. Producer holds D/S/in_valid. Changing S while stalled is legal, and routing is re-evaluated each cycle with no stickiness.
- Yk and Vk are stable while Vk=1 & Rk=0.
- Rk asserted while Vk=0 is ignored.
- in_valid=0 → no state change except drains.
- All outputs except in_ready are registered.

Optional Feature:
- Macro DEMUX_BEAT_CNT_EN.
- Defined: beat_cnt increments by 1 on every accept and wraps modulo 2^CNT_W (0xFFFF+1 → 0x0000). It is cleared by rst. There is no increment on cycles without accept, including stalls.
- Undefined: no counter logic is synthesized and beat_cnt is tied to 0. The port list is unchanged.

Test Plan:
- Reset: assert rst mid-cycle with V2=1 → V1..V4=0, Y1..Y4=0, in_ready=0 immediately, without waiting for clk. Release rst → in_ready=1.
- Routing: all R=1; send D=0x11,S=00; D=0x22,S=01; D=0x33,S=10; D=0x44,S=11 on consecutive cycles. Expect Y1=0x11, Y2=0x22, Y3=0x33, Y4=0x44, each Vk pulsing one cycle after its accept. No Vk asserts for the wrong channel.
- Backpressure: R3=0; send D=0xA5,S=10 → V3=1, Y3=0xA5. Next beat D=0x5A,S=10 stalls (in_ready=0, Y3 holds 0xA5). Meanwhile D=0x77,S=00 is accepted to Y1. Raise R3 → 0x5A loads the same cycle 0xA5 drains, and V3 stays 1.
- Back-to-back same channel: R4=1 held; 8 beats D=0..7,S=11 on consecutive cycles. Expect in_ready=1 throughout, Y4 sequence 0..7 in order, one cycle late.
- Reset mid-operation: V1=V3=1 with R=0, assert rst → both cleared. Post-reset the first beat D=0xC3,S=00 appears on Y1 after 1 cycle.
- DEMUX_BEAT_CNT_EN defined: preload via 0xFFFE accepts (or force), then 3 accepts → beat_cnt 0xFFFF, 0x0000, 0x0001. Stalled cycles leave the count unchanged. Undefined: beat_cnt=0 always.
